// File: rtl/genius_sequence_player_if.sv
// Command, key-echo and sequence-write bundle between the game controller and
// the Genius sequence player, plus the player's speaker and status outputs.
interface genius_sequence_player_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W:0]   level;
  logic              key_valid;
  logic [2:0]        key;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_data;
  logic [2:0]        thing;
  logic              SE;
  logic              busy;
  logic              done;

  modport master (
    output start, level, key_valid, key, wr_en, wr_addr, wr_data,
    input  thing, SE, busy, done
  );

  modport slave (
    input  start, level, key_valid, key, wr_en, wr_addr, wr_data,
    output thing, SE, busy, done
  );
endinterface

// File: rtl/genius_sequence_player.sv
// Plays the first `level` notes of the stored Genius sequence as timed tones
// with silent gaps, and echoes single key presses while idle.
module genius_sequence_player #(
  parameter int MAX_LEN    = 32,
  parameter int ADDR_W     = 5,
  parameter int NOTE_TICKS = 25000000,
  parameter int GAP_TICKS  = 12500000,
  parameter int CNT_W      = 25
) (
  input logic                     clk,
  input logic                     rst_n,
  genius_sequence_player_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] NOTE      = 3'd1;
  localparam logic [2:0] GAP       = 3'd2;
  localparam logic [2:0] DONE      = 3'd3;
  localparam logic [2:0] ECHO_NOTE = 3'd4;
  localparam logic [2:0] ECHO_GAP  = 3'd5;

  localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS - 1);
  localparam logic [ADDR_W:0]  MAX_LVL   = (ADDR_W+1)'(MAX_LEN);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   len;
  logic [2:0]        mem [MAX_LEN];
  logic [2:0]        thing_r;
  logic              se_r;
  logic              done_r;

  logic              cnt_zero;
  logic              last_note;
  logic [ADDR_W-1:0] idx_nxt;
  logic [ADDR_W:0]   lvl_clamped;
  logic              wr_ok;

  assign cnt_zero    = (cnt == '0);
  assign last_note   = ({1'b0, idx} == (len - 1'b1));
  assign idx_nxt     = idx + 1'b1;
  assign lvl_clamped = (int'(bus.level) > MAX_LEN) ? MAX_LVL : bus.level;
  assign wr_ok       = bus.wr_en && (int'(bus.wr_addr) < MAX_LEN);

  // Writes commit at the edge, so a note-start read in the same cycle sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      len     <= '0;
      thing_r <= '0;
      se_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          // start takes priority; a start with level 0 also swallows any key press.
          if (bus.start) begin
            if (bus.level != '0) begin
              len     <= lvl_clamped;
              idx     <= '0;
              thing_r <= mem[0];
              se_r    <= 1'b1;
              cnt     <= NOTE_LOAD;
              state   <= NOTE;
            end
          end else if (bus.key_valid) begin
            thing_r <= bus.key;
            se_r    <= 1'b1;
            cnt     <= NOTE_LOAD;
            state   <= ECHO_NOTE;
          end
        end
        NOTE, ECHO_NOTE: begin
          if (cnt_zero) begin
            se_r  <= 1'b0;
            cnt   <= GAP_LOAD;
            state <= (state == NOTE) ? GAP : ECHO_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt_zero) begin
            if (last_note) begin
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              idx     <= idx_nxt;
              thing_r <= mem[idx_nxt];
              se_r    <= 1'b1;
              cnt     <= NOTE_LOAD;
              state   <= NOTE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ECHO_GAP: begin
          if (cnt_zero) state <= IDLE;
          else          cnt   <= cnt - 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.thing = thing_r;
  assign bus.SE    = se_r;
  assign bus.done  = done_r;
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_genius_sequence_player.sv
// Directed and randomized bench for genius_sequence_player, compared against a
// per-cycle waveform built from the stored sequence and the note/gap timing.
module tb_genius_sequence_player;
  localparam int MAX_LEN = 32;
  localparam int ADDR_W  = 5;
  localparam int NT      = 4;
  localparam int GT      = 2;
  localparam int CNT_W   = 3;
  localparam int SLOT    = NT + GT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  genius_sequence_player_if #(.ADDR_W(ADDR_W)) bus();

  genius_sequence_player #(
    .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .NOTE_TICKS(NT), .GAP_TICKS(GT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] model [MAX_LEN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic se, input logic [2:0] th,
                            input logic b, input logic d);
    check({tag, ".SE"},    32'(bus.SE),    32'(se));
    check({tag, ".thing"}, 32'(bus.thing), 32'(th));
    check({tag, ".busy"},  32'(bus.busy),  32'(b));
    check({tag, ".done"},  32'(bus.done),  32'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.level = '0; bus.key_valid = 1'b0; bus.key = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
  endtask

  task automatic wr(input int a, input logic [2:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a[ADDR_W-1:0]; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    model[a] = d;
  endtask

  // Each note occupies SLOT cycles: NT with sound, GT silent. The value of a note
  // is whatever the memory held just before the edge that starts it.
  task automatic play(input string tag, input int lvl, input logic kv, input logic [2:0] k,
                      input int sc, input int wc0, input int wa0, input int wd0,
                      input int wc1, input int wa1, input int wd1);
    int n;
    int tot;
    logic [2:0] cur;
    logic [2:0] nxt;
    n   = (lvl > MAX_LEN) ? MAX_LEN : lvl;
    tot = n * SLOT;
    cur = model[0];
    nxt = cur;
    bus.start = 1'b1; bus.level = lvl[ADDR_W:0]; bus.key_valid = kv; bus.key = k;
    tick();
    idle_inputs();
    for (int c = 0; c < tot; c++) begin
      int ph;
      int note;
      ph   = c % SLOT;
      note = c / SLOT;
      check_outs(tag, ph < NT, cur, 1'b1, 1'b0);
      bus.start = (c == sc); bus.level = 6'd5; bus.wr_en = 1'b0;
      if (ph == SLOT - 1 && note < n - 1) nxt = model[note + 1];
      if (c == wc0) begin
        bus.wr_en = 1'b1; bus.wr_addr = wa0[ADDR_W-1:0]; bus.wr_data = wd0[2:0];
        model[wa0] = wd0[2:0];
      end
      if (c == wc1) begin
        bus.wr_en = 1'b1; bus.wr_addr = wa1[ADDR_W-1:0]; bus.wr_data = wd1[2:0];
        model[wa1] = wd1[2:0];
      end
      tick();
      if (ph == SLOT - 1) cur = nxt;
    end
    idle_inputs();
    check_outs({tag, ".donecyc"}, 1'b0, cur, 1'b1, 1'b1);
    tick();
    check_outs({tag, ".after"}, 1'b0, cur, 1'b0, 1'b0);
  endtask

  task automatic echo(input string tag, input logic [2:0] k);
    bus.key_valid = 1'b1; bus.key = k;
    tick();
    idle_inputs();
    for (int c = 0; c < SLOT; c++) begin
      check_outs(tag, c < NT, k, 1'b1, 1'b0);
      tick();
    end
    check_outs({tag, ".after"}, 1'b0, k, 1'b0, 1'b0);
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < MAX_LEN; i++) model[i] = '0;
    #12;
    check_outs("reset", 1'b0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    wr(0, 3'd5); wr(1, 3'd1); wr(2, 3'd7);
    play("play3", 3, 1'b0, 3'd0, -1, -1, 0, 0, -1, 0, 0);

    bus.start = 1'b1; bus.level = '0;
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      check("lvl0.SE", 32'(bus.SE), 32'd0);
      check("lvl0.busy", 32'(bus.busy), 32'd0);
      check("lvl0.done", 32'(bus.done), 32'd0);
      tick();
    end

    for (int i = 0; i < MAX_LEN; i++) wr(i, 3'($urandom_range(0, 7)));
    play("lvl40", 40, 1'b0, 3'd0, -1, -1, 0, 0, -1, 0, 0);

    echo("echo3", 3'd3);

    wr(0, 3'd2);
    play("contend", 1, 1'b1, 3'd6, -1, -1, 0, 0, -1, 0, 0);

    wr(0, 3'd1); wr(1, 3'd4); wr(2, 3'd3);
    play("midstart", 3, 1'b0, 3'd0, 7, -1, 0, 0, -1, 0, 0);

    wr(0, 3'd3); wr(1, 3'd0);
    play("livewr", 2, 1'b0, 3'd0, -1, 1, 0, 4, 2, 1, 6);

    for (int r = 0; r < 8; r++) begin
      int lvl;
      lvl = $urandom_range(1, 8);
      for (int i = 0; i < lvl; i++) wr(i, 3'($urandom_range(0, 7)));
      play("rand", lvl, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           int'($urandom_range(0, lvl * SLOT - 1)),
           int'($urandom_range(0, lvl * SLOT - 1)), int'($urandom_range(0, lvl - 1)),
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, lvl * SLOT - 1)), int'($urandom_range(0, lvl - 1)),
           int'($urandom_range(0, 7)));
      echo("randecho", 3'($urandom_range(0, 7)));
    end

    wr(0, 3'd5); wr(1, 3'd6); wr(2, 3'd7);
    bus.start = 1'b1; bus.level = 6'd3;
    tick();
    idle_inputs();
    for (int c = 0; c < 7; c++) tick();
    check_outs("prerst", 1'b1, 3'd6, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("asyncrst", 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < MAX_LEN; i++) model[i] = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("inrst.done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check_outs("postrst", 1'b0, 3'd0, 1'b0, 1'b0);
    play("clearedmem", 1, 1'b0, 3'd0, -1, -1, 0, 0, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
